// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced, synchronous switch level into
// press/release/long-press/double-click pulses, all registered.
module button_event_decoder #(
  parameter int LONG_LIMIT   = 12500000,
  parameter int DOUBLE_LIMIT = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Debounced,
  output logic       o_Press,
  output logic       o_Release,
  output logic       o_Long,
  output logic       o_Double,
  output logic       o_Held,
  output logic [2:0] o_State
);

  localparam int MAX_LIMIT = (LONG_LIMIT > DOUBLE_LIMIT) ? LONG_LIMIT : DOUBLE_LIMIT;
  localparam int CW        = $clog2(MAX_LIMIT + 1);
  localparam logic [CW-1:0] LONG_C   = CW'(LONG_LIMIT);
  localparam logic [CW-1:0] DOUBLE_C = CW'(DOUBLE_LIMIT);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESSED = 3'd1,
    S_LONG    = 3'd2,
    S_GAP     = 3'd3,
    S_SECOND  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          held_q, held_d;
  logic          press_edge_s;
  logic          release_edge_s;
  logic [CW-1:0] cnt_inc_s;

  assign press_edge_s   = i_Debounced & ~prev_q;
  assign release_edge_s = ~i_Debounced & prev_q;
  assign cnt_inc_s      = cnt_q + ONE_C;

  // Next-state, counter and pulse decode for the event at the current edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = i_Debounced;
    held_d    = prev_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press_edge_s) begin
          press_d = 1'b1;
          cnt_d   = ONE_C;
          state_d = S_PRESSED;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PRESSED, S_SECOND: begin
        if (i_Debounced) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == LONG_C) begin
            long_d  = 1'b1;
            state_d = S_LONG;
          end else begin
            state_d = state_q;
          end
        end else if (release_edge_s) begin
          release_d = 1'b1;
          if (state_q == S_PRESSED) begin
            cnt_d   = ONE_C;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LONG: begin
        // A long hold ends in IDLE so it never opens a double-click window
        if (release_edge_s) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end else if (!i_Debounced) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LONG;
        end
      end

      S_GAP: begin
        if (press_edge_s) begin
          press_d  = 1'b1;
          double_d = 1'b1;
          cnt_d    = ONE_C;
          state_d  = S_SECOND;
        end else if (i_Debounced) begin
          press_d = 1'b1;
          cnt_d   = ONE_C;
          state_d = S_PRESSED;
        end else if (cnt_q >= DOUBLE_C) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, previous sample and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      double_q  <= double_d;
      held_q    <= held_d;
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Long    = long_q;
  assign o_Double  = double_q;
  assign o_Held    = held_q;
  assign o_State   = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed scoreboard bench for button_event_decoder (LONG_LIMIT=8, DOUBLE_LIMIT=5).
module tb_button_event_decoder;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Debounced = 1'b0;
  logic       o_Press, o_Release, o_Long, o_Double, o_Held;
  logic [2:0] o_State;

  int compared = 0;
  int mismatched = 0;

  // pulses = {double, long, release, press}
  typedef struct {
    int         edge_n;
    logic [3:0] pulses;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  localparam logic [3:0] P  = 4'b0001;
  localparam logic [3:0] R  = 4'b0010;
  localparam logic [3:0] L  = 4'b0100;
  localparam logic [3:0] PD = 4'b1001;
  localparam logic [3:0] NO = 4'b0000;

  button_event_decoder #(.LONG_LIMIT(8), .DOUBLE_LIMIT(5)) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Debounced (i_Debounced),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Long      (o_Long),
    .o_Double    (o_Double),
    .o_Held      (o_Held),
    .o_State     (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [3:0] p, input logic [2:0] st);
    exp_t e;
    e.edge_n = k;
    e.pulses = p;
    e.st     = st;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] v;
    v = 64'd0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulses"}, -1, {4'd0, o_Double, o_Long, o_Release, o_Press}, 8'h00);
    check({tag, "_held"}, -1, {7'd0, o_Held}, 8'h00);
    check({tag, "_state"}, -1, {5'd0, o_State}, 8'h00);
  endtask

  task automatic do_reset(input logic din);
    @(negedge i_Clk);
    i_Debounced = din;
    i_Rst_L = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
  endtask

  // Drive pat[k] for edge k (edge 0 = first edge after reset release)
  task automatic run(input logic [63:0] pat, input int n);
    exp_t e;
    logic [3:0] obs;
    for (int k = 0; k < n; k++) begin
      i_Debounced = pat[k];
      @(posedge i_Clk);
      #1;
      obs = {o_Double, o_Long, o_Release, o_Press};
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e = sb.pop_front();
        check("pulses", k, {4'd0, obs}, {4'd0, e.pulses});
        check("state", k, {5'd0, o_State}, {5'd0, e.st});
      end else begin
        check("quiet", k, {4'd0, obs}, 8'h00);
      end
      check("held", k, {7'd0, o_Held}, {7'd0, (k == 0) ? 1'b0 : pat[k-1]});
    end
    check("sb_drained", n, sb.size() > 255 ? 8'hFF : 8'(sb.size()), 8'h00);
    sb.delete();
  endtask

  initial begin
    #2;
    check_reset_outputs("por");

    // Short press then timed-out window
    do_reset(1'b0);
    push(10, P, 3'd1); push(13, R, 3'd3); push(18, NO, 3'd0);
    run(bits(10, 12), 24);

    // Long press, then a later plain press
    do_reset(1'b0);
    push(10, P, 3'd1); push(17, L, 3'd2); push(21, R, 3'd0);
    push(23, P, 3'd1); push(26, R, 3'd3);
    run(bits(10, 20) | bits(23, 25), 30);

    // Double click at the inclusive window edge
    do_reset(1'b0);
    push(10, P, 3'd1); push(13, R, 3'd3); push(18, PD, 3'd4); push(20, R, 3'd0);
    run(bits(10, 12) | bits(18, 19), 24);

    // One cycle too late: plain press
    do_reset(1'b0);
    push(10, P, 3'd1); push(13, R, 3'd3); push(18, NO, 3'd0);
    push(19, P, 3'd1); push(21, R, 3'd3);
    run(bits(10, 12) | bits(19, 20), 24);

    // Toggling every cycle: double, plain, double...
    do_reset(1'b0);
    for (int k = 10; k <= 21; k++) begin
      case ((k - 10) % 4)
        0: push(k, P, 3'd1);
        1: push(k, R, 3'd3);
        2: push(k, PD, 3'd4);
        default: push(k, R, 3'd0);
      endcase
    end
    run(bits(10, 10) | bits(12, 12) | bits(14, 14) | bits(16, 16) |
        bits(18, 18) | bits(20, 20), 26);

    // Second press held into a long press
    do_reset(1'b0);
    push(10, P, 3'd1); push(13, R, 3'd3); push(15, PD, 3'd4);
    push(22, L, 3'd2); push(26, R, 3'd0);
    run(bits(10, 12) | bits(15, 25), 30);

    // Asynchronous reset during PRESSED, input held high through release
    do_reset(1'b0);
    push(10, P, 3'd1);
    run(bits(10, 63), 14);
    check("pre_rst_state", 13, {5'd0, o_State}, 8'h01);
    #2;
    i_Rst_L = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    push(0, P, 3'd1); push(7, L, 3'd2);
    run(bits(0, 63), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
